ppe_rr_arb_w1024: RTL and testbench



---
 rtl/ppe_pkg.sv | 10 +
 rtl/pe_lsb_w1024.sv | 23 ++
 rtl/ppe_rr_arb_w1024.sv | 125 ++++++++++++
 tb/tb_ppe_rr_arb_w1024.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ppe_pkg.sv
// Shared constants and types for the programmable priority encoder stages.
package ppe_pkg;

  localparam int PPE_WIDTH = 1024;
  localparam int PPE_IDX_W = 10;

  typedef logic [PPE_WIDTH-1:0] ppe_vec_t;
  typedef logic [PPE_IDX_W-1:0] ppe_idx_t;

endpackage : ppe_pkg

// File: rtl/pe_lsb_w1024.sv
// Combinational lowest-set-bit encoder over a 1024-bit vector.
// idx is 0 when no bit is set; found reports whether any bit is set.
module pe_lsb_w1024
  import ppe_pkg::*;
(
  input  ppe_vec_t vec,
  output ppe_idx_t idx,
  output logic     found
);

  // Scan from the top down so the last hit (the lowest set bit) wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    idx = '0;
    for (int i = PPE_WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = ppe_idx_t'(i);
    end
  end

  // Any set bit means a winner exists.
  assign found = |vec;

endmodule : pe_lsb_w1024

// File: rtl/ppe_rr_arb_w1024.sv
// Round-robin grant stage: request register (S1) feeding a grant register (S2).
// The winner is the lowest request at or above ptr, wrapping to bit 0.
// The below-pointer mask (thermo) comes from the external thermometer stage
// driven by ptr.
// Optional feature macro: PPE_PTR_LOAD_EN adds ptr_load/ptr_load_val so the
// pointer can be loaded directly; a load beats a same-cycle grant update.
module ppe_rr_arb_w1024
  import ppe_pkg::*;
#(
  parameter int WIDTH = PPE_WIDTH,
  parameter int IDX_W = PPE_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] ptr,
  input  logic [WIDTH-1:0] thermo,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_found
`ifdef PPE_PTR_LOAD_EN
  ,
  input  logic             ptr_load,
  input  logic [IDX_W-1:0] ptr_load_val
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_req_q,   s1_req_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
  logic             gnt_found_q, gnt_found_d;
  logic [IDX_W-1:0] ptr_q,       ptr_d;

  logic             s1_adv;
  logic             accept;
  logic [WIDTH-1:0] hi;
  ppe_idx_t         hi_idx,   all_idx;
  logic             hi_found, all_found;
  logic [IDX_W-1:0] win_idx;

  // S1 moves into S2 whenever S2 is empty or is being drained this cycle.
  assign s1_adv    = s1_valid_q && (!gnt_valid_q || gnt_ready);
  assign req_ready = !rst && (!s1_valid_q || s1_adv);
  assign accept    = req_valid && req_ready;

  // Requests at or above the pointer take priority; otherwise wrap to bit 0.
  assign hi = s1_req_q & ~thermo;

  pe_lsb_w1024 u_pe_hi (
    .vec   (hi),
    .idx   (hi_idx),
    .found (hi_found)
  );

  pe_lsb_w1024 u_pe_all (
    .vec   (s1_req_q),
    .idx   (all_idx),
    .found (all_found)
  );

  // all_idx is already 0 for an empty request, which is the required idle index.
  assign win_idx = hi_found ? hi_idx : all_idx;

  // Next-state for S1, S2 and the round-robin pointer.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_req_d    = s1_req_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_found_d = gnt_found_q;
    ptr_d       = ptr_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_req_d   = req;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      gnt_valid_d = 1'b1;
      gnt_idx_d   = win_idx;
      gnt_found_d = all_found;
      // 10-bit add wraps 1023 to 0 on its own.
      if (all_found) ptr_d = win_idx + IDX_W'(1);
    end else if (gnt_valid_q && gnt_ready) begin
      gnt_valid_d = 1'b0;
    end

`ifdef PPE_PTR_LOAD_EN
    // The grant above was computed with the old pointer; the load still wins.
    if (ptr_load) ptr_d = ptr_load_val;
`endif
  end

  // State registers with synchronous reset; reset discards any pending work.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      gnt_found_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_req_q    <= s1_req_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_found_q <= gnt_found_d;
      ptr_q       <= ptr_d;
    end
  end

  assign ptr       = ptr_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_found = gnt_found_q;

endmodule : ppe_rr_arb_w1024

// File: tb/tb_ppe_rr_arb_w1024.sv
// Directed self-checking bench for ppe_rr_arb_w1024. The thermometer stage
// is modelled here as thermo[i] = (i < ptr).
module tb_ppe_rr_arb_w1024;
  import ppe_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  ppe_vec_t         req;
  ppe_idx_t         ptr;
  ppe_vec_t         thermo;
  logic             gnt_valid;
  logic             gnt_ready;
  ppe_idx_t         gnt_idx;
  logic             gnt_found;
`ifdef PPE_PTR_LOAD_EN
  logic             ptr_load;
  ppe_idx_t         ptr_load_val;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ppe_rr_arb_w1024 dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req          (req),
    .ptr          (ptr),
    .thermo       (thermo),
    .gnt_valid    (gnt_valid),
    .gnt_ready    (gnt_ready),
    .gnt_idx      (gnt_idx),
    .gnt_found    (gnt_found)
`ifdef PPE_PTR_LOAD_EN
    ,
    .ptr_load     (ptr_load),
    .ptr_load_val (ptr_load_val)
`endif
  );

  // External thermometer stage model.
  always_comb begin
    thermo = '0;
    for (int i = 0; i < PPE_WIDTH; i++) thermo[i] = (i < int'(ptr));
  end

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ppe_vec_t bits2(input int a, input int b);
    ppe_vec_t v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  // Offer one request for a single edge, then grant appears one edge later.
  task automatic one_grant(input ppe_vec_t v);
    req       = v;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req       = '0;
    gnt_ready = 1'b1;
`ifdef PPE_PTR_LOAD_EN
    ptr_load     = 1'b0;
    ptr_load_val = '0;
`endif
    repeat (3) step();
    check("req_ready_in_reset", int'(req_ready), 0);
    rst = 1'b0;
    #1;
    check("reset_ptr", int'(ptr), 0);
    check("reset_gnt_valid", int'(gnt_valid), 0);
    check("reset_gnt_idx", int'(gnt_idx), 0);
    check("req_ready_after_reset", int'(req_ready), 1);

    // First grant from ptr 0: lowest of {5,900} is 5.
    one_grant(bits2(5, 900));
    check("first_valid", int'(gnt_valid), 1);
    check("first_idx", int'(gnt_idx), 5);
    check("first_found", int'(gnt_found), 1);
    check("first_ptr", int'(ptr), 6);

    // Move pointer to 901 via a grant on bit 900.
    one_grant(bits2(900, -1));
    check("to901_idx", int'(gnt_idx), 900);
    check("to901_ptr", int'(ptr), 901);

    // Wrap: nothing at or above 901, so lowest overall wins.
    one_grant(bits2(5, 900));
    check("wrap_idx", int'(gnt_idx), 5);
    check("wrap_ptr", int'(ptr), 6);

    // Grant bit 1023 twice: second time from ptr 0, pointer wraps to 0 again.
    one_grant(bits2(1023, -1));
    check("top1_idx", int'(gnt_idx), 1023);
    check("top1_ptr", int'(ptr), 0);
    one_grant(bits2(1023, -1));
    check("top2_idx", int'(gnt_idx), 1023);
    check("top2_ptr", int'(ptr), 0);
    step();
    check("top_clear_valid", int'(gnt_valid), 0);

    // Back-to-back 0xF with gnt_ready high: 0,1,2,3.
    req       = ppe_vec_t'(4'hF);
    req_valid = 1'b1;
    step();
    step();
    check("b2b_idx0", int'(gnt_idx), 0);
    check("b2b_ready0", int'(req_ready), 1);
    step();
    check("b2b_idx1", int'(gnt_idx), 1);
    step();
    check("b2b_idx2", int'(gnt_idx), 2);
    req_valid = 1'b0;
    step();
    check("b2b_idx3", int'(gnt_idx), 3);
    check("b2b_valid3", int'(gnt_valid), 1);
    check("b2b_ptr", int'(ptr), 4);
    step();
    check("b2b_clear", int'(gnt_valid), 0);

    // Empty request: not found, index 0, pointer unchanged.
    one_grant('0);
    check("empty_valid", int'(gnt_valid), 1);
    check("empty_found", int'(gnt_found), 0);
    check("empty_idx", int'(gnt_idx), 0);
    check("empty_ptr", int'(ptr), 4);
    step();

    // Backpressure: A=bit10 granted and held, B=bit3 parks in S1, C=bit20 waits.
    gnt_ready = 1'b0;
    req       = bits2(10, -1);
    req_valid = 1'b1;
    step();
    req = bits2(3, -1);
    step();
    req = bits2(20, -1);
    #1;
    check("bp_ready_full", int'(req_ready), 0);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp_idx_c%0d", c), int'(gnt_idx), 10);
      check($sformatf("bp_valid_c%0d", c), int'(gnt_valid), 1);
      check($sformatf("bp_ptr_c%0d", c), int'(ptr), 11);
      check($sformatf("bp_ready_c%0d", c), int'(req_ready), 0);
    end
    gnt_ready = 1'b1;
    step();
    // B from ptr 11 wraps to 3; C is accepted on the same edge.
    req_valid = 1'b0;
    check("bp_b_idx", int'(gnt_idx), 3);
    check("bp_b_ptr", int'(ptr), 4);
    step();
    check("bp_c_idx", int'(gnt_idx), 20);
    check("bp_c_valid", int'(gnt_valid), 1);
    check("bp_c_ptr", int'(ptr), 21);
    step();
    check("bp_clear", int'(gnt_valid), 0);

`ifdef PPE_PTR_LOAD_EN
    // Load in the same cycle as a grant: grant uses old ptr, load wins.
    req       = bits2(30, -1);
    req_valid = 1'b1;
    step();
    req_valid    = 1'b0;
    ptr_load     = 1'b1;
    ptr_load_val = ppe_idx_t'(700);
    step();
    ptr_load = 1'b0;
    check("load_idx", int'(gnt_idx), 30);
    check("load_ptr", int'(ptr), 700);
    one_grant(bits2(5, 900));
    check("load_next_idx", int'(gnt_idx), 900);
    check("load_next_ptr", int'(ptr), 901);
    step();
`endif

    // Reset mid-operation: accepted request is discarded, no grant.
    req       = bits2(50, -1);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    rst       = 1'b1;
    step();
    check("midrst_valid", int'(gnt_valid), 0);
    check("midrst_ptr", int'(ptr), 0);
    rst = 1'b0;
    step();
    step();
    check("midrst_no_grant", int'(gnt_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_ppe_rr_arb_w1024
